// File: rtl/pwm_prot_pkg.sv
// Shared types and constants for the PWM protection gate.
// Imported by pwm_protection_gate and pwm_leg_monitor.
package pwm_prot_pkg;

  localparam int unsigned NUM_LEGS_DEFAULT = 4;

  // Bit positions within fault_code.
  localparam int unsigned FC_SHOOT = 0;
  localparam int unsigned FC_DT    = 1;
  localparam int unsigned FC_EXT   = 2;
  localparam int unsigned FC_PULSE = 3;

  typedef enum logic [1:0] {
    StSafe,
    StArming,
    StRun,
    StFault
  } state_e;

endpackage

// File: rtl/pwm_leg_monitor.sv
// Per-leg violation detector: shoot-through, dead-time and (with PWM_PROT_MINPULSE_EN)
// narrow-pulse flags, all combinational on the current gate request.
module pwm_leg_monitor #(
  parameter int unsigned DT_WIDTH         = 8,
  parameter int unsigned MIN_PULSE_CYCLES = 20
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          pwm_i,
  input  logic                run_entry_i,
  input  logic [DT_WIDTH-1:0] min_deadtime_i,
  output logic                shoot_o,
  output logic                dt_o,
  output logic                pulse_o
);

  logic [1:0]          prev_q;
  logic [1:0]          rise;
  logic [DT_WIDTH-1:0] dt_q, dt_d;

  // Presetting on RUN entry keeps the first legal turn-on from looking like a violation.
  always_comb begin
    dt_d = '0;
    if (run_entry_i) begin
      dt_d = '1;
    end else if (pwm_i == 2'b00) begin
      dt_d = (dt_q == '1) ? dt_q : dt_q + DT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= 2'b00;
      dt_q   <= '0;
    end else begin
      prev_q <= pwm_i;
      dt_q   <= dt_d;
    end
  end

  assign rise    = pwm_i & ~prev_q;
  assign shoot_o = &pwm_i;
  assign dt_o    = (|rise) && (min_deadtime_i != '0) && (dt_q < min_deadtime_i);

`ifdef PWM_PROT_MINPULSE_EN
  localparam int unsigned OnW = $clog2(MIN_PULSE_CYCLES + 1);

  logic [1:0][OnW-1:0] on_q, on_d;
  logic [1:0]          fall;
  logic [1:0]          short_on;

  assign fall = prev_q & ~pwm_i;

  always_comb begin
    for (int b = 0; b < 2; b++) begin
      on_d[b]     = '0;
      if (pwm_i[b]) begin
        on_d[b] = (on_q[b] == '1) ? on_q[b] : on_q[b] + OnW'(1);
      end
      short_on[b] = fall[b] && (on_q[b] < OnW'(MIN_PULSE_CYCLES));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      on_q <= '0;
    end else begin
      on_q <= on_d;
    end
  end

  assign pulse_o = |short_on;
`else
  logic unused_min_pulse;
  assign unused_min_pulse = ^MIN_PULSE_CYCLES;
  assign pulse_o          = 1'b0;
`endif

endmodule

// File: rtl/pwm_protection_gate.sv
// Gates 5-level PWM gate requests to the driver pins; trips to FAULT on shoot-through,
// short dead-time, external driver fault or (with PWM_PROT_MINPULSE_EN) narrow pulses.
module pwm_protection_gate
  import pwm_prot_pkg::*;
#(
  parameter int unsigned NUM_LEGS         = NUM_LEGS_DEFAULT,
  parameter int unsigned DT_WIDTH         = 8,
  parameter int unsigned MIN_PULSE_CYCLES = 20
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [2*NUM_LEGS-1:0] pwm_in,
  input  logic                  sync_pulse,
  input  logic                  arm,
  input  logic                  fault_clear,
  input  logic                  ext_fault_n,
  input  logic [DT_WIDTH-1:0]   min_deadtime,
  output logic [2*NUM_LEGS-1:0] pwm_out,
  output logic                  running,
  output logic                  fault,
  output logic [3:0]            fault_code,
  output logic [1:0]            fault_leg,
  output logic [7:0]            trip_count
);

  localparam int unsigned NumGates = 2 * NUM_LEGS;

  state_e              state_q, state_d;
  logic                ext_meta_q, ext_ok_q;
  logic                arm_q;
  logic [NumGates-1:0] pwm_out_q, pwm_out_d;
  logic                running_q, fault_q;
  logic [3:0]          code_q, code_d, cause;
  logic [1:0]          leg_q, leg_d, hit_leg;
  logic [7:0]          trips_q, trips_d;
  logic [NUM_LEGS-1:0] shoot_v, dt_v, pulse_v, leg_hit;
  logic                in_run, run_entry, any_fault, trip;

  assign in_run    = (state_q == StRun);
  assign run_entry = (state_d == StRun) && !in_run;

  for (genvar k = 0; k < NUM_LEGS; k++) begin : g_leg
    pwm_leg_monitor #(
      .DT_WIDTH        (DT_WIDTH),
      .MIN_PULSE_CYCLES(MIN_PULSE_CYCLES)
    ) u_leg_monitor (
      .clk           (clk),
      .rst_n         (rst_n),
      .pwm_i         (pwm_in[2*k +: 2]),
      .run_entry_i   (run_entry),
      .min_deadtime_i(min_deadtime),
      .shoot_o       (shoot_v[k]),
      .dt_o          (dt_v[k]),
      .pulse_o       (pulse_v[k])
    );
  end

  assign leg_hit = shoot_v | dt_v | pulse_v;

  // Leg violations only count in RUN; an external fault also aborts ARMING.
  always_comb begin
    cause = '0;
    if (in_run) begin
      cause[FC_SHOOT] = |shoot_v;
      cause[FC_DT]    = |dt_v;
      cause[FC_PULSE] = |pulse_v;
    end
    if (in_run || (state_q == StArming)) begin
      cause[FC_EXT] = !ext_ok_q;
    end
  end

  assign any_fault = |cause;

  always_comb begin
    hit_leg = '0;
    for (int k = NUM_LEGS - 1; k >= 0; k--) begin
      if (leg_hit[k]) begin
        hit_leg = 2'(k);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StSafe: begin
        if (arm && !arm_q && ext_ok_q) state_d = StArming;
      end
      StArming: begin
        if (any_fault)       state_d = StFault;
        else if (!arm)       state_d = StSafe;
        else if (sync_pulse) state_d = StRun;
      end
      StRun: begin
        if (any_fault) state_d = StFault;
        else if (!arm) state_d = StSafe;
      end
      StFault: begin
        if (fault_clear && ext_ok_q) state_d = StSafe;
      end
    endcase
  end

  assign trip = (state_d == StFault) && (state_q != StFault);

  always_comb begin
    code_d  = code_q;
    leg_d   = leg_q;
    trips_d = trips_q;
    if (trip) begin
      code_d = code_q | cause;
      leg_d  = hit_leg;
      if (trips_q != 8'hFF) trips_d = trips_q + 8'd1;
    end else if ((state_q == StFault) && (state_d == StSafe)) begin
      code_d = '0;
      leg_d  = '0;
    end
  end

  assign pwm_out_d = (in_run && !any_fault) ? pwm_in : '0;

  // arm_q resets high so an arm level held through reset is not seen as a fresh edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StSafe;
      ext_meta_q <= 1'b1;
      ext_ok_q   <= 1'b1;
      arm_q      <= 1'b1;
      pwm_out_q  <= '0;
      running_q  <= 1'b0;
      fault_q    <= 1'b0;
      code_q     <= '0;
      leg_q      <= '0;
      trips_q    <= '0;
    end else begin
      state_q    <= state_d;
      ext_meta_q <= ext_fault_n;
      ext_ok_q   <= ext_meta_q;
      arm_q      <= arm;
      pwm_out_q  <= pwm_out_d;
      running_q  <= (state_d == StRun);
      fault_q    <= (state_d == StFault);
      code_q     <= code_d;
      leg_q      <= leg_d;
      trips_q    <= trips_d;
    end
  end

  assign pwm_out    = pwm_out_q;
  assign running    = running_q;
  assign fault      = fault_q;
  assign fault_code = code_q;
  assign fault_leg  = leg_q;
  assign trip_count = trips_q;

endmodule

// File: doc/pwm_protection_gate.md
Name: pwm_protection_gate

Overview:
- Sits directly downstream of the 5-level PWM generator, between its eight gate signals and the gate-driver pins.
- Passes PWM through only while armed and healthy. Detects:
  - shoot-through;
  - dead-time shorter than a programmed minimum;
  - external driver fault.
- On any fault, forces all gates low within one clock and latches a diagnostic code until software clears it.
- Entry to RUN is aligned to the generator's carrier sync_pulse.

Parameters:
- NUM_LEGS, 4, number of half-bridge legs (two gate bits per leg).
- DT_WIDTH, 8, width of dead-time counters and min_deadtime.
- MIN_PULSE_CYCLES, 20, minimum legal on-pulse in clocks (used only with optional feature).

Ports:
- clk  in  1  system clock (100 MHz).
- rst_n  in  1  asynchronous active-low reset.
- pwm_in  in  2*NUM_LEGS  gate requests from generator.
  - Bit 2k = high switch of leg k, bit 2k+1 = low switch.
  - Legs 0..3 = bridge1 ch1, bridge1 ch2, bridge2 ch1, bridge2 ch2.
- sync_pulse  in  1  carrier-peak strobe from generator, one cycle wide.
- arm  in  1  software arm request (level; rising edge acts).
- fault_clear  in  1  software fault acknowledge, one-cycle strobe.
- ext_fault_n  in  1  asynchronous active-low driver fault (DESAT/UVLO).
- min_deadtime  in  DT_WIDTH  required both-off cycles before any turn-on; 0 disables the check.
- pwm_out  out  2*NUM_LEGS  gated gate drive to pins.
- running  out  1  high in RUN state.
- fault  out  1  high in FAULT state.
- fault_code  out  4  sticky cause flags: [0] shoot-through, [1] dead-time, [2] external, [3] narrow pulse.
- fault_leg  out  2  lowest-indexed leg implicated in the tripping cycle (0 for external-only trips).
- trip_count  out  8  saturating count of entries into FAULT.

Behaviour:
- Clocking and reset:
  - One clock.
  - Reset is asynchronous and active-low (rst_n); the polarity and synchronicity are fixed.
  - Reset values: pwm_out=0, running=0, fault=0, fault_code=0, fault_leg=0, trip_count=0, state=SAFE.
- ext_fault_n synchronisation:
  - Passes through a 2-flop synchroniser, so it takes 2-3 cycles to act.
  - Both synchroniser flops reset to 1 (no fault).
- pwm_prev register:
  - Holds last cycle's pwm_in.
  - Used for edge detection.
- Per-leg dead-time counter:
  - Increments while both bits of pwm_in for that leg are 0.
  - Resets to 0 when either bit is 1.
  - Saturates at 2^DT_WIDTH-1.
  - Preset to saturated value on every entry to RUN.
- Per-cycle fault detection, combinational on current pwm_in, evaluated only in RUN:
  - Shoot-through: both bits of a leg = 1.
  - Dead-time: a 0->1 edge on either bit of a leg, with counter < min_deadtime and min_deadtime != 0.
  - External: synchronised ext_fault_n = 0.
- FSM states and transitions:
  - SAFE -> ARMING on arm rising edge, provided synchronised ext_fault_n = 1. Otherwise stay in SAFE.
  - ARMING -> RUN on the first sync_pulse.
  - ARMING -> SAFE if arm drops.
  - ARMING -> FAULT on an external fault.
  - RUN -> FAULT on any detected fault. This takes priority over arm dropping.
  - RUN -> SAFE on arm = 0.
  - FAULT -> SAFE on fault_clear with synchronised ext_fault_n = 1. fault_clear while the external fault is still active is ignored.
  - Leaving FAULT never restarts RUN automatically; a fresh arm rising edge is required.
- pwm_out timing:
  - Registered: pwm_out <= (state==RUN && no fault detected this cycle) ? pwm_in : 0.
  - Latency is 1 cycle.
  - The offending pattern never reaches pwm_out.
- Fault latching:
  - On a FAULT entry, OR all detected causes into fault_code.
  - Latch fault_leg.
  - Increment trip_count, saturating at 255.
  - fault_code and fault_leg are cleared on FAULT->SAFE.
- Outputs in non-RUN states: pwm_out = 0 in SAFE, ARMING and FAULT.
- running = (state==RUN); fault = (state==FAULT); both registered.

Optional Feature:
- Macro: PWM_PROT_MINPULSE_EN.
- Enabled:
  - A per-switch on-time counter runs while the switch is on.
  - On a 1->0 edge with on-time < MIN_PULSE_CYCLES, set fault_code[3] and trip to FAULT on that cycle.
- Disabled:
  - No on-time counters are built.
  - fault_code[3] is tied to 0.

Decomposition:
- Package pwm_prot_pkg:
  - State enum (SAFE, ARMING, RUN, FAULT).
  - Fault-code bit index constants (FC_SHOOT=0, FC_DT=1, FC_EXT=2, FC_PULSE=3).
  - NUM_LEGS default.
- Sub-module pwm_leg_monitor, instantiated NUM_LEGS times:
  - Holds the dead-time counter, edge detect, shoot-through check, and optional on-time counter.
  - Outputs per-leg violation flags.
- Top level holds the synchroniser, FSM, output gating, fault latching and trip counter.

Test Plan:
- Arm sequencing: arm rising, then sync_pulse 40 cycles later -> running=1 exactly one cycle after sync_pulse, and pwm_out equals pwm_in delayed by 1 cycle.
- Shoot-through: in RUN, pwm_in=8'b0000_1100 (leg1 both on) -> next cycle pwm_out=0, fault=1, fault_code=4'b0001, fault_leg=1, trip_count=1.
- Dead-time: min_deadtime=100, leg2 low switch off then high switch on after 60 cycles -> fault_code=4'b0010, fault_leg=2. Repeat with a 100-cycle gap -> no fault. Repeat with min_deadtime=0 and a 1-cycle gap -> no fault.
- External fault: ext_fault_n low in RUN -> pwm_out=0 within 3 cycles, fault_code[2]=1. fault_clear while the pin is still low -> remains FAULT. Pin high, then fault_clear -> SAFE, fault_code=0, running stays 0 until a new arm edge.
- Reset mid-run: assert rst_n=0 while pwm_out is active -> pwm_out=0 immediately (asynchronous). After release -> SAFE even if arm is held high.
- With PWM_PROT_MINPULSE_EN and MIN_PULSE_CYCLES=20: a 10-cycle high pulse on leg0 -> fault_code=4'b1000. Without the macro -> no trip.
